// File: rtl/debug_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the debug_regs slave, with a no-ack watchdog.
// Grant is registered (1-cycle request latency), data path is combinational; a stalled master sees ack=0.
module debug_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic       r_last_grant, w_last_grant_nxt;  // 0 = m0, 1 = m1
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_to_pend, w_to_pend_nxt;        // forced-termination cycle
  logic       r_timeout;

  logic w_req0, w_req1;
  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_to_pend    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_to_pend    <= w_to_pend_nxt;
      if (w_to_pend_nxt) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = 8'd0;
    w_to_pend_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_state_nxt = r_last_grant ? GNT0 : GNT1;
        else if (w_req0)      w_state_nxt = GNT0;
        else if (w_req1)      w_state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_last_grant_nxt = 1'b0;
          w_state_nxt      = w_req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_last_grant_nxt = 1'b1;
          w_state_nxt      = w_req0 ? GNT0 : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A genuine ack in the limit cycle wins; a grant change restarts the count.
    if (r_state != IDLE && w_state_nxt == r_state && s_stb_o && !s_ack_i) begin
      if (r_cnt == LP_CNT_MAX) w_to_pend_nxt = 1'b1;
      else                     w_cnt_nxt     = r_cnt + 8'd1;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'd0;
    grant_o  = 2'b00;
    case (r_state)
      GNT0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i & ~r_to_pend;
        s_stb_o  = m0_stb_i & ~r_to_pend;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = r_to_pend | s_ack_i;
        m0_dat_o = r_to_pend ? TIMEOUT_DATA : s_dat_i;
      end
      GNT1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i & ~r_to_pend;
        s_stb_o  = m1_stb_i & ~r_to_pend;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = r_to_pend | s_ack_i;
        m1_dat_o = r_to_pend ? TIMEOUT_DATA : s_dat_i;
      end
      default: ;
    endcase
  end

  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_debug_wb_arbiter.sv
// Directed bench for debug_wb_arbiter with a small debug_regs slave model (optionally never acks).
module tb_debug_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdat = 32'd0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  logic [31:0] reg1 = 32'd0, reg2 = 32'd0;
  logic        stub = 1'b0;
  int          checks = 0, errors = 0;
  logic [31:0] d;
  int          n;

  debug_wb_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Slave model: registered single-cycle ack, registers at 0x08 and 0x0C.
  always @(posedge clk) begin
    if (s_cyc_o && s_stb_o && !s_ack && !stub) begin
      s_ack <= 1'b1;
      if (s_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) begin
            if (s_adr_o == 32'h8) reg1[b*8 +: 8] <= s_dat_o[b*8 +: 8];
            else if (s_adr_o == 32'hC) reg2[b*8 +: 8] <= s_dat_o[b*8 +: 8];
          end
        end
      end
      s_rdat <= (s_adr_o == 32'h8) ? reg1 : (s_adr_o == 32'hC) ? reg2 : 32'd0;
    end else begin
      s_ack <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_set(input int m, input logic on, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_wdat = dat;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_wdat = dat;
    end
  endtask

  task automatic wait_ack(input int m, output logic [31:0] rd, output int cnt);
    cnt = 0;
    rd  = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (((m == 0) ? m0_ack_o : m1_ack_o) === 1'b1) begin
        rd  = (m == 0) ? m0_dat_o : m1_dat_o;
        cnt = i;
        break;
      end
    end
    checks++;
    assert (cnt != 0) else begin
      errors++;
      $error("FAIL ack_wait m%0d: observed=no ack expected=ack within 40 cycles", m);
    end
  endtask

  task automatic beat(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      output logic [31:0] rd, output int cnt);
    m_set(m, 1'b1, we, adr, wd);
    wait_ack(m, rd, cnt);
    m_set(m, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    m_set(0, 1'b0, 1'b0, 32'd0, 32'd0);
    m_set(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    repeat (5) tick();
    check("idle_grant", 32'(grant_o), 32'd0);
    check("idle_m0_ack", 32'(m0_ack_o), 32'd0);
    check("idle_m1_ack", 32'(m1_ack_o), 32'd0);
    check("idle_m0_dat", m0_dat_o, 32'd0);
    check("idle_m1_dat", m1_dat_o, 32'd0);
    check("idle_s_cyc", 32'(s_cyc_o), 32'd0);
    check("idle_timeout", 32'(timeout_o), 32'd0);

    // 2: m0 write/read 0x08
    beat(0, 1'b1, 32'h8, 32'h56534431, d, n);
    check("m0_wr_latency", 32'(n), 32'd2);
    check("m0_wr_grant", 32'(grant_o), 32'h1);
    check("m0_wr_m1_ack", 32'(m1_ack_o), 32'd0);
    check("m0_wr_m1_dat", m1_dat_o, 32'd0);
    tick();
    check("m0_ack_pulse", 32'(m0_ack_o), 32'd0);
    check("m0_release_grant", 32'(grant_o), 32'd0);
    beat(0, 1'b0, 32'h8, 32'd0, d, n);
    check("m0_rd_data", d, 32'h56534431);
    check("m0_rd_grant", 32'(grant_o), 32'h1);
    tick();

    // 3: m1 write/read 0x0C
    beat(1, 1'b1, 32'hC, 32'h52495343, d, n);
    check("m1_wr_grant", 32'(grant_o), 32'h2);
    check("m1_wr_m0_ack", 32'(m0_ack_o), 32'd0);
    tick();
    beat(1, 1'b0, 32'hC, 32'd0, d, n);
    check("m1_rd_data", d, 32'h52495343);
    check("m1_rd_latency", 32'(n), 32'd2);
    tick();

    // 4: simultaneous requests right after reset
    rst = 1'b1; tick(); rst = 1'b0;
    m_set(0, 1'b1, 1'b1, 32'h8, 32'h11112222);
    m_set(1, 1'b1, 1'b1, 32'hC, 32'h33334444);
    tick();
    check("tie_grant_m0", 32'(grant_o), 32'h1);
    check("tie_m1_stall_ack", 32'(m1_ack_o), 32'd0);
    wait_ack(0, d, n);
    check("tie_m0_ack_latency", 32'(n), 32'd1);
    check("tie_m1_ack_during_m0", 32'(m1_ack_o), 32'd0);
    m_set(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("handover_grant_m1", 32'(grant_o), 32'h2);
    wait_ack(1, d, n);
    check("handover_m1_latency", 32'(n), 32'd1);
    m_set(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("after_m1_idle", 32'(grant_o), 32'd0);
    m_set(0, 1'b1, 1'b0, 32'h8, 32'd0);
    m_set(1, 1'b1, 1'b0, 32'hC, 32'd0);
    tick();
    check("tie2_grant_m0", 32'(grant_o), 32'h1);
    wait_ack(0, d, n);
    check("tie2_m0_rd_data", d, 32'h11112222);
    m_set(0, 1'b0, 1'b0, 32'd0, 32'd0);
    m_set(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    // 5: slave never acks -> watchdog
    stub = 1'b1;
    m_set(0, 1'b1, 1'b0, 32'h8, 32'd0);
    wait_ack(0, d, n);
    check("wd_latency", 32'(n), 32'd17);
    check("wd_data", d, 32'hDEADBEEF);
    check("wd_s_cyc_masked", 32'(s_cyc_o), 32'd0);
    check("wd_timeout_flag", 32'(timeout_o), 32'd1);
    m_set(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("wd_ack_one_cycle", 32'(m0_ack_o), 32'd0);
    check("wd_timeout_sticky", 32'(timeout_o), 32'd1);
    stub = 1'b0;
    beat(0, 1'b0, 32'h8, 32'd0, d, n);
    check("wd_recover_data", d, 32'h11112222);
    check("wd_recover_latency", 32'(n), 32'd2);
    tick();
    check("wd_timeout_sticky2", 32'(timeout_o), 32'd1);

    // 6: reset while m1 read is pending
    m_set(1, 1'b1, 1'b0, 32'hC, 32'd0);
    tick();
    check("rst_pre_grant_m1", 32'(grant_o), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_grant_idle", 32'(grant_o), 32'd0);
    check("rst_m1_ack_dropped", 32'(m1_ack_o), 32'd0);
    check("rst_timeout_clear", 32'(timeout_o), 32'd0);
    tick();
    check("rst_regrant_m1", 32'(grant_o), 32'h2);
    wait_ack(1, d, n);
    check("rst_retry_data", d, 32'h33334444);
    m_set(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_wb_arbiter.md
Name: debug_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single `debug_regs` slave port (`debug_reg_1` @ 0x08, `debug_reg_2` @ 0x0C).
- Master 0 is the management-SoC Wishbone bus; master 1 is the logic-analyzer / GPIO-driven debug master.
- Grants use round-robin over whole bus cycles (held while the granted master's CYC is high).
- A watchdog terminates any slave access that never acks, so neither master can hang the bus.

Parameters:
- TIMEOUT_CYCLES, 16, cycles STB may stay high without slave ACK before a forced termination; legal range 2..255.
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned to the master on a forced termination.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_sel_i  in  4  master 0 byte select
- m0_adr_i, m0_dat_i  in  32 each  master 0 address / write data
- m0_ack_o  out  1  ack to master 0
- m0_dat_o  out  32  read data to master 0
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to `debug_regs` wbs_cyc_i / wbs_stb_i / wbs_we_i
- s_sel_o  out  4  to wbs_sel_i
- s_adr_o, s_dat_o  out  32 each  to wbs_adr_i / wbs_dat_i
- s_ack_i  in  1  from wbs_ack_o
- s_dat_i  in  32  from wbs_dat_o
- grant_o  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = idle
- timeout_o  out  1  sticky flag: at least one forced termination since reset

Behaviour:
- Clock/reset: one clock, wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values:
  - state = IDLE, grant_o = 00, last_grant = m1 (so m0 wins the first tie), timeout counter = 0, timeout_o = 0.
  - All slave outputs = 0; m0_ack_o = m1_ack_o = 0; m0_dat_o = m1_dat_o = 0.
- States: IDLE, GNT0, GNT1.
  - A request is mx_cyc_i & mx_stb_i.
- IDLE:
  - Only one master requesting: go to GNTx at the next edge.
  - Both requesting: grant the master that is not last_grant.
  - Grant latency is 1 cycle from request to routing.
- GNTx, routing (combinational, registered grant):
  - s_* = mx_* for CYC, STB, WE, SEL, ADR, DAT.
  - mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
  - The non-granted master sees ack = 0 and dat = 0 while its request stalls.
- GNTx, hold and release:
  - Grant is held while mx_cyc_i = 1, including STB gaps and back-to-back beats.
  - When mx_cyc_i = 0 at an edge, last_grant <= x.
  - If the other master is requesting at that edge, hand over directly to GNT(other); otherwise go to IDLE.
  - No dead cycle on handover; s_cyc_o is 0 for one cycle only if routing yields it (the new master's inputs drive it).
- Watchdog:
  - Counter increments each cycle in GNTx with s_stb_o = 1 and s_ack_i = 0.
  - Counter clears on s_ack_i, on STB low, and on a grant change.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack:
    - the next cycle masks s_stb_o = 0 and s_cyc_o = 0;
    - the arbiter drives mx_ack_o = 1 and mx_dat_o = TIMEOUT_DATA for exactly one cycle;
    - timeout_o <= 1; the counter clears.
  - If s_ack_i arrives in the same cycle the limit is reached, the genuine ack wins and no timeout is flagged.
- Slave ack outside grant: s_ack_i while in IDLE is ignored and not forwarded.
- Reset mid-transaction: at the edge with wb_rst_i = 1, the grant drops and all outputs return to reset values; the pending slave ack is discarded.
- Single-cycle ack pulse: if the granted master holds STB for one cycle after ack (late deassert), it is a new beat, forwarded normally.

Test Plan:
1. Idle after reset, no requests for 5 cycles -> grant_o = 00, all acks = 0, m*_dat_o = 0, s_cyc_o = 0.
2. m0 writes 0x56534431 ("VSD1") to 0x08, then reads 0x08 -> m0_ack_o pulses each beat; read returns 0x56534431; grant_o = 01 throughout; m1 outputs remain 0.
3. m1 writes 0x52495343 ("RISC") to 0x0C and reads it back -> 0x52495343; grant_o = 10.
4. m0 and m1 both raise CYC/STB in the same cycle right after reset:
   - m0 is served first; m1 stalls (m1_ack_o = 0);
   - on m0 CYC drop, grant hands directly to m1 with no IDLE cycle;
   - a repeated tie is then won by m0 again (last_grant = m1).
5. Slave replaced by a stub that never acks, m0 read at 0x08:
   - after 16 cycles of STB, m0_ack_o = 1 for one cycle with m0_dat_o = 0xDEADBEEF;
   - timeout_o = 1 and stays 1;
   - a subsequent access to real `debug_regs` completes normally.
6. Assert wb_rst_i for 1 cycle while m1 is mid-read (STB high, ack pending) -> next cycle grant_o = 00, m1_ack_o = 0, timeout_o = 0; after reset release, m1 retrying is re-granted 1 cycle later.
